// File: rtl/uart_frame_pkg.sv
// ============================================================================
// Module   : uart_frame_pkg
// Purpose  : Shared types and constants for the UART frame engine.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_frame_pkg;

  localparam int C_DBIT  = 8;
  localparam int C_NB_OP = 6;

  localparam logic [2:0] C_ST_GET_A  = 3'd0;
  localparam logic [2:0] C_ST_GET_B  = 3'd1;
  localparam logic [2:0] C_ST_GET_OP = 3'd2;
  localparam logic [2:0] C_ST_EXEC   = 3'd3;
  localparam logic [2:0] C_ST_SEND   = 3'd4;

  typedef enum logic [2:0] {
    ST_GET_A  = C_ST_GET_A,
    ST_GET_B  = C_ST_GET_B,
    ST_GET_OP = C_ST_GET_OP,
    ST_EXEC   = C_ST_EXEC,
    ST_SEND   = C_ST_SEND
  } state_t;

  // Only the mid-frame byte waits are allowed to expire.
  function automatic logic is_timed_state(input state_t s);
    return (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_frame_fifo_if.sv
// ============================================================================
// Module   : uart_frame_fifo_if
// Purpose  : RX/TX FIFO handshake plus ALU operand/result bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_frame_fifo_if
  import uart_frame_pkg::*;
#(
  parameter int DBIT  = C_DBIT,
  parameter int NB_OP = C_NB_OP
);

  logic             rx_empty;
  logic [DBIT-1:0]  r_data;
  logic             rd_uart;
  logic             tx_full;
  logic             wr_uart;
  logic [DBIT-1:0]  w_data;
  logic [DBIT-1:0]  alu_a;
  logic [DBIT-1:0]  alu_b;
  logic [NB_OP-1:0] alu_op;
  logic [DBIT-1:0]  alu_result;
  logic             frame_done;
  logic             timeout_err;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, frame_done, timeout_err
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, frame_done, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_frame_timer.sv
// ============================================================================
// Module   : uart_frame_timer
// Purpose  : Inter-byte timeout counter; expire is a same-cycle pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_timer
  import uart_frame_pkg::*;
#(
  parameter int TO_CYCLES = 50000,
  parameter int TO_BIT    = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic en,
  output logic      expire
);

  localparam logic [TO_BIT-1:0] C_LAST = TO_BIT'(TO_CYCLES - 1);

  logic [TO_BIT-1:0] r_count;

  assign expire = en & (r_count == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || expire) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_if.sv
// ============================================================================
// Module   : uart_frame_if
// Purpose  : Pops A, B, opcode from the RX FIFO, drives an external ALU and
//            pushes the result byte into the TX FIFO. Optional inter-byte
//            timeout is compiled in with UART_FRAME_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_if
  import uart_frame_pkg::*;
#(
  parameter int DBIT      = C_DBIT,
  parameter int NB_OP     = C_NB_OP,
  parameter int TO_CYCLES = 50000,
  parameter int TO_BIT    = 16
) (
  input wire logic          clk,
  input wire logic          reset,
  uart_frame_fifo_if.master bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [DBIT-1:0]  r_alu_a;
  logic [DBIT-1:0]  r_alu_b;
  logic [NB_OP-1:0] r_alu_op;
  logic [DBIT-1:0]  r_w_data;
  logic             w_pop;
  logic             w_push;
  logic             w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_GET_A: begin
        w_pop = ~bus.rx_empty;
        if (w_pop) w_state_next = ST_GET_B;
      end
      ST_GET_B: begin
        w_pop = ~bus.rx_empty;
        if (w_pop)          w_state_next = ST_GET_OP;
        else if (w_timeout) w_state_next = ST_GET_A;
      end
      ST_GET_OP: begin
        w_pop = ~bus.rx_empty;
        if (w_pop)          w_state_next = ST_EXEC;
        else if (w_timeout) w_state_next = ST_GET_A;
      end
      ST_EXEC: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_push = ~bus.tx_full;
        if (w_push) w_state_next = ST_GET_A;
      end
      default: begin
        w_state_next = ST_GET_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_GET_A;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_w_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        case (r_state)
          ST_GET_A:  r_alu_a  <= bus.r_data;
          ST_GET_B:  r_alu_b  <= bus.r_data;
          ST_GET_OP: r_alu_op <= bus.r_data[NB_OP-1:0];
          default:   ;
        endcase
      end
      if (r_state == ST_EXEC) r_w_data <= bus.alu_result;
    end
  end

`ifdef UART_FRAME_TIMEOUT_EN
  logic w_timed;
  logic w_expire;

  assign w_timed = is_timed_state(r_state);

  // Counter is held clear outside GET_B/GET_OP so each wait starts at zero.
  uart_frame_timer #(
    .TO_CYCLES (TO_CYCLES),
    .TO_BIT    (TO_BIT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (~w_timed | w_pop),
    .en     (w_timed & bus.rx_empty),
    .expire (w_expire)
  );

  assign w_timeout = w_expire;
`else
  assign w_timeout = 1'b0;
`endif

  // rd_uart is combinational from GET_A, so it is masked while reset is held.
  assign bus.rd_uart     = w_pop & reset;
  assign bus.wr_uart     = w_push;
  assign bus.frame_done  = w_push;
  assign bus.timeout_err = w_timeout & reset;
  assign bus.w_data      = r_w_data;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_if.sv
// ============================================================================
// Module   : tb_uart_frame_if
// Purpose  : Scoreboard bench for uart_frame_if with show-ahead FIFO models.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_if;
  import uart_frame_pkg::*;

  localparam int DBIT      = 8;
  localparam int NB_OP     = 6;
  localparam int TO_CYCLES = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_frame_fifo_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();

  uart_frame_if #(
    .DBIT      (DBIT),
    .NB_OP     (NB_OP),
    .TO_CYCLES (TO_CYCLES),
    .TO_BIT    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ALU model: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR
  always_comb begin
    bus.alu_result = 8'h00;
    case (bus.alu_op)
      6'h20: bus.alu_result = bus.alu_a + bus.alu_b;
      6'h22: bus.alu_result = bus.alu_a - bus.alu_b;
      6'h24: bus.alu_result = bus.alu_a & bus.alu_b;
      6'h25: bus.alu_result = bus.alu_a | bus.alu_b;
      6'h26: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];
  int         pop_cyc[$];
  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int wr_cnt = 0;
  int to_cnt = 0;
  int last_wr_cyc = -1;
  int last_to_cyc = -1;
  bit rd_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: observes outputs mid-cycle and checks pushes against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      rd_seen = bus.rd_uart;
      if (bus.rd_uart) begin
        pop_cnt++;
        pop_cyc.push_back(cyc);
      end
      if (bus.timeout_err) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (bus.rd_uart && bus.wr_uart) check("rd_wr_exclusive", 32'd1, 32'd0);
      if (bus.wr_uart || bus.frame_done) check("frame_done_eq_wr", bus.frame_done, bus.wr_uart);
      if (bus.wr_uart) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_push", 32'd1, 32'd0);
        else check("w_data", bus.w_data, exp_q.pop_front());
      end
    end
  end

  // Show-ahead RX FIFO: pointer advances just after the edge that ends a pop cycle.
  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
      bus.rx_empty = (rxq.size() == 0);
      bus.r_data   = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int k = 0;
    while (pop_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, pop_cnt, target);
  endtask

  task automatic wait_wrs(input int target, input int budget, input string name);
    int k = 0;
    while (wr_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    check(name, wr_cnt, target);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_uart"},     bus.rd_uart,     32'd0);
    check({tag, "_wr_uart"},     bus.wr_uart,     32'd0);
    check({tag, "_frame_done"},  bus.frame_done,  32'd0);
    check({tag, "_timeout_err"}, bus.timeout_err, 32'd0);
    check({tag, "_w_data"},      bus.w_data,      32'd0);
    check({tag, "_alu_a"},       bus.alu_a,       32'd0);
    check({tag, "_alu_b"},       bus.alu_b,       32'd0);
    check({tag, "_alu_op"},      bus.alu_op,      32'd0);
  endtask

  initial begin
    int p, w, t, x, pa;
    bus.tx_full = 1'b0;
    step(3);
    check_idle("in_reset");
    reset = 1'b1;
    step(2);
    check_idle("after_reset");

    // Reset mid-frame after A has been taken
    rxq.push_back(8'h12);
    wait_pops(1, 20, "pop_A_0x12");
    step(1);
    check("alu_a_before_reset", bus.alu_a, 32'h12);
    reset = 1'b0;
    #1;
    check_idle("mid_frame_reset");
    step(2);
    reset = 1'b1;
    step(1);
    p = pop_cnt; w = wr_cnt;
    rxq.push_back(8'h05); rxq.push_back(8'h03); rxq.push_back(8'h20);
    exp_q.push_back(8'h08);
    wait_pops(p + 3, 40, "frame1_pops");
    wait_wrs(w + 1, 40, "frame1_push");
    step(5);
    check("frame1_single_push", wr_cnt, w + 1);

    // Preloaded FIFO: best-case 5-cycle frame
    pop_cyc.delete();
    p = pop_cnt; w = wr_cnt;
    rxq.push_back(8'h0F); rxq.push_back(8'hF0); rxq.push_back(8'h24);
    exp_q.push_back(8'h00);
    wait_pops(p + 3, 20, "frame2_pops");
    wait_wrs(w + 1, 20, "frame2_push");
    check("pop_gap_0_1", pop_cyc[1] - pop_cyc[0], 32'd1);
    check("pop_gap_1_2", pop_cyc[2] - pop_cyc[1], 32'd1);
    check("first_pop_to_push", last_wr_cyc - pop_cyc[0], 32'd4);
    check("frame2_alu_a", bus.alu_a, 32'h0F);
    check("frame2_alu_b", bus.alu_b, 32'hF0);
    check("frame2_alu_op", bus.alu_op, 32'h24);

    // TX FIFO full while in SEND; next frame queued behind it
    bus.tx_full = 1'b1;
    p = pop_cnt; w = wr_cnt;
    rxq.push_back(8'h30); rxq.push_back(8'h12); rxq.push_back(8'h22);
    exp_q.push_back(8'h1E);
    wait_pops(p + 3, 20, "frame3_pops");
    step(2);
    rxq.push_back(8'h07); rxq.push_back(8'h02); rxq.push_back(8'h26);
    exp_q.push_back(8'h05);
    p = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("held_w_data", bus.w_data, 32'h1E);
    end
    check("no_push_while_full", wr_cnt, w);
    check("no_pop_while_full", pop_cnt, p);
    bus.tx_full = 1'b0;
    x = cyc;
    wait_wrs(w + 1, 10, "frame3_push");
    check("push_on_release_cycle", last_wr_cyc, x);
    wait_wrs(w + 2, 40, "frame4_push");

    // Bytes trickling in 7 cycles apart
    p = pop_cnt; w = wr_cnt;
    rxq.push_back(8'h44);
    step(7);
    rxq.push_back(8'h11);
    step(7);
    rxq.push_back(8'h25);
    exp_q.push_back(8'h55);
    wait_pops(p + 3, 20, "trickle_pops");
    wait_wrs(w + 1, 20, "trickle_push");
    step(3);
    check("trickle_pop_count", pop_cnt, p + 3);
    check("trickle_push_count", wr_cnt, w + 1);
    check("trickle_alu_a", bus.alu_a, 32'h44);
    check("trickle_alu_b", bus.alu_b, 32'h11);
    check("trickle_alu_op", bus.alu_op, 32'h25);

    // Partial frame: A only, then silence
    pop_cyc.delete();
    p = pop_cnt; w = wr_cnt; t = to_cnt;
    rxq.push_back(8'h5A);
    wait_pops(p + 1, 20, "lone_A_pop");
    pa = pop_cyc[0];
    step(40);
`ifdef UART_FRAME_TIMEOUT_EN
    check("timeout_pulses", to_cnt - t, 32'd1);
    check("timeout_latency", last_to_cyc - pa, 32'd20);
    rxq.push_back(8'h09); rxq.push_back(8'h04); rxq.push_back(8'h22);
    exp_q.push_back(8'h05);
    wait_wrs(w + 1, 40, "post_timeout_push");
    check("post_timeout_alu_a", bus.alu_a, 32'h09);
`else
    check("no_timeout_pulse", to_cnt - t, 32'd0);
    step(960);
    check("no_push_while_waiting", wr_cnt, w);
    rxq.push_back(8'h09); rxq.push_back(8'h22);
    exp_q.push_back(8'h51);
    wait_wrs(w + 1, 40, "late_frame_push");
    check("late_frame_alu_a", bus.alu_a, 32'h5A);
    check("no_timeout_ever", to_cnt - t, 32'd0);
`endif

    step(5);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
